// File: rtl/fir_tcdm_responder.sv
// Single-bank TCDM responder for MP hci_core initiator ports, round-robin arbitrated.
// Optional random grant stalls via `define FIR_TCDM_RESP_STALL_EN.
module fir_tcdm_responder #(
   parameter int unsigned MP         = 3,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NB_WORDS   = 1024
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [MP-1:0]                       req_i,
   output logic [MP-1:0]                       gnt_o,
   input  logic [MP-1:0][ADDR_WIDTH-1:0]       add_i,
   input  logic [MP-1:0]                       wen_i,
   input  logic [MP-1:0][DATA_WIDTH/8-1:0]     be_i,
   input  logic [MP-1:0][DATA_WIDTH-1:0]       data_i,
   output logic [MP-1:0][DATA_WIDTH-1:0]       r_data_o,
   output logic [MP-1:0]                       r_valid_o,
   output logic                                busy_o
);

   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned IDX_W = $clog2(NB_WORDS);
   localparam int unsigned PTR_W = (MP > 1) ? $clog2(MP) : 1;

   logic [DATA_WIDTH-1:0] mem_q [NB_WORDS];

   logic [PTR_W-1:0]      ptr_q;
   logic [PTR_W-1:0]      arb_idx;
   logic [PTR_W-1:0]      cand;
   logic                  arb_found;
   logic [MP-1:0]         arb_gnt;
   logic                  stall;
   logic                  gnt_en;

   logic [ADDR_WIDTH-1:0] sel_add;
   logic                  sel_wen;
   logic [BE_W-1:0]       sel_be;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [IDX_W-1:0]      sel_idx;
   logic                  unused_add;

   // First requester at or after the pointer, wrapping modulo MP.
   always_comb begin
      arb_idx   = '0;
      arb_found = 1'b0;
      arb_gnt   = '0;
      cand      = '0;
      for (int i = 0; i < int'(MP); i++) begin
         cand = PTR_W'((int'(ptr_q) + i) % int'(MP));
         if (!arb_found && req_i[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
      if (arb_found) begin
         arb_gnt[arb_idx] = 1'b1;
      end
   end

`ifdef FIR_TCDM_RESP_STALL_EN
   logic [15:0] lfsr_q;
   logic        lfsr_fb;

   assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   assign stall   = lfsr_q[0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
      end
   end
`else
   assign stall = 1'b0;
`endif

   assign gnt_en = arb_found & ~rst_i & ~stall;
   assign gnt_o  = gnt_en ? arb_gnt : '0;
   assign busy_o = ~rst_i & ((|req_i) | (|r_valid_o));

   assign sel_add  = add_i[arb_idx];
   assign sel_wen  = wen_i[arb_idx];
   assign sel_be   = be_i[arb_idx];
   assign sel_data = data_i[arb_idx];
   assign sel_idx  = sel_add[IDX_W+1:2];

   // Upper bits alias (address wrap) and the byte offset is ignored.
   assign unused_add = ^{sel_add[ADDR_WIDTH-1:IDX_W+2], sel_add[1:0]};

   always_ff @(posedge clk_i) begin
      if (gnt_en && !sel_wen) begin
         for (int b = 0; b < int'(BE_W); b++) begin
            if (sel_be[b]) begin
               mem_q[sel_idx][8*b +: 8] <= sel_data[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q     <= '0;
         r_valid_o <= '0;
         r_data_o  <= '0;
      end else begin
         r_valid_o <= '0;
         if (gnt_en) begin
            ptr_q <= (arb_idx == PTR_W'(MP - 1)) ? '0 : arb_idx + 1'b1;
            if (sel_wen) begin
               r_valid_o[arb_idx] <= 1'b1;
               r_data_o[arb_idx]  <= mem_q[sel_idx];
            end
         end
      end
   end

endmodule

// File: doc/fir_tcdm_responder.md
Name: fir_tcdm_responder

Overview:
- Behavioural-synthesizable TCDM responder for the target side of MP hci_core initiator channels, as driven by the FIR accelerator streamer.
- Single-bank word memory arbitrated round-robin among MP ports.
- Used as the memory end in standalone FIR benches and in FPGA bring-up.
- Responds to loads (x, h) and stores (y) with the HCI core timing: grant in the request cycle, read data one cycle later.

Parameters:
- MP, 3, number of initiator ports served.
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- ADDR_WIDTH, 32, byte-address width per port.
- NB_WORDS, 1024, memory depth in words; power of 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  [MP-1:0]  request per port.
- gnt_o  out  [MP-1:0]  grant per port.
- add_i  in  [MP-1:0][ADDR_WIDTH-1:0]  byte address.
- wen_i  in  [MP-1:0]  1 = read, 0 = write.
- be_i  in  [MP-1:0][DATA_WIDTH/8-1:0]  byte enables.
- data_i  in  [MP-1:0][DATA_WIDTH-1:0]  write data.
- r_data_o  out  [MP-1:0][DATA_WIDTH-1:0]  read data.
- r_valid_o  out  [MP-1:0]  read-data valid.
- busy_o  out  1  high while any req_i is high or a read response is pending.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - r_valid_o = 0, r_data_o = 0, round-robin pointer = 0.
  - gnt_o is combinational and is forced to 0 while rst_i is high.
  - Memory contents are NOT reset.
  - Reset mid-transaction drops any pending r_valid.
- Arbitration:
  - At most one grant per cycle. gnt_o is combinational from req_i and the pointer.
  - The granted port is the first requesting port at or after the pointer index, modulo MP.
  - On a grant to port k, the pointer becomes (k+1) mod MP at the next edge. With no grant, the pointer holds.
- Handshake:
  - A transaction completes when req_i[k] and gnt_o[k] are both high in the same cycle.
  - Initiators hold add/wen/be/data stable until granted. A non-granted request carries over, with no side effects.
- Address decode:
  - Word index = add_i[$clog2(NB_WORDS)+1 : 2].
  - Upper bits are ignored, so addresses wrap modulo NB_WORDS*DATA_WIDTH/8.
  - Low two bits are ignored; no misalignment error.
- Write (wen=0):
  - Bytes with be=1 are updated at the granted edge; other bytes are preserved.
  - No r_valid is generated.
  - be = 0 is a legal no-op.
- Read (wen=1):
  - Latency is exactly 1 cycle. In the cycle after the grant, r_valid_o[k] = 1 and r_data_o[k] = the full memory word; be is ignored.
  - r_valid is a single-cycle pulse. r_data_o[k] holds its last value while r_valid_o[k] is low.
- Ordering:
  - Write to word A in cycle t, then read of A granted in cycle t+1: returns the new data.
  - Single grant per cycle means no same-cycle read/write conflict.
- Back-to-back:
  - One port requesting every cycle is granted every cycle and gets r_valid every cycle.
  - With all MP ports requesting continuously, each port is granted exactly once per MP cycles.
- busy_o = |req_i or |r_valid pending; busy_o = 0 in reset.

Optional Feature:
- Macro: FIR_TCDM_RESP_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - When LFSR bit 0 = 1, all gnt_o are forced to 0 that cycle and the pointer does not advance.
  - Exercises streamer back-pressure.
- When undefined: no LFSR; grants follow arbitration only.

Test Plan:
1. Write then read: port 0 writes 32'hDEADBEEF to 0x40 with be=4'hF; port 0 then reads 0x40 -> gnt same cycle, r_valid_o[0] one cycle later, r_data_o[0] = 32'hDEADBEEF.
2. Byte enables: preload 0x10 = 32'h11223344; write 32'hAABBCCDD with be=4'b0101; read -> 32'h11BB33DD.
3. Round-robin fairness: all 3 ports issue 6 reads each, continuously, from reset -> grant order 0,1,2,0,1,2,... Each port gets 6 r_valid pulses; no gnt_o has more than one bit set.
4. Wrap-around: NB_WORDS=1024; write 32'h5 to 0x1000; read 0x0 -> 32'h5.
5. Reset mid-read: grant a read on port 2, assert rst_i in the next cycle -> r_valid_o = 0 after that edge, pointer = 0, previously written data still readable after reset.
6. Stall variant (with FIR_TCDM_RESP_STALL_EN): 100 continuous reads on port 1 -> every read is eventually granted; a grant never occurs in a cycle where LFSR bit 0 = 1; data matches the reference model.
